// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and priority state for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic {PRI0, PRI1} prio_state_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way grant with a round-robin (or fixed) priority flop
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);
  prio_state_t state;
  assign grant0 = reset && !flush && valid0 && (!valid1 || state == PRI0);
  assign grant1 = reset && !flush && valid1 && (!valid0 || state == PRI1);
  // The last winner yields priority to the other requester
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= PRI0;
    else if (flush || FIXED_PRIO) state <= PRI0;
    else if (grant0) state <= PRI1;
    else if (grant1) state <= PRI0;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and load writebacks onto one register-file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              collision
);
  logic              xfer;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO != 0)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (req0_ready),
    .grant1 (req1_ready)
  );
  assign xfer = req0_ready || req1_ready;
  assign rd   = req1_ready ? req1_rd : req0_rd;
  assign data = req1_ready ? req1_data : req0_data;
  // x0 is hardwired zero: accept the transfer but never write it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_en     <= 1'b0;
      wr_rd     <= '0;
      wr_data   <= '0;
      collision <= 1'b0;
    end else begin
      wr_en     <= xfer && rd != '0;
      collision <= req0_valid && req1_valid && req0_rd == req1_rd && req0_rd != '0;
      if (xfer) begin
        wr_rd   <= rd;
        wr_data <= data;
      end
    end
  a_onehot: assert property (@(posedge clk) disable iff (!reset) !(req0_ready && req1_ready));
  a_hold0: assert property (@(posedge clk) disable iff (!reset)
    req0_valid && !req0_ready && !flush |=> req0_valid && $stable(req0_rd) && $stable(req0_data));
  a_hold1: assert property (@(posedge clk) disable iff (!reset)
    req1_valid && !req1_ready && !flush |=> req1_valid && $stable(req1_rd) && $stable(req1_data));
endmodule
